// File: rtl/ysyx_22041207_ifu_buf.sv
// Instruction fetch unit: one outstanding imem request, DEPTH-entry instruction FIFO
// to decode, epoch-squashed redirects and misaligned-target fault entries.
module ysyx_22041207_ifu_buf #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_take,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            jalr_take,
    input  logic [XLEN-1:0] jalr_r1,
    input  logic [XLEN-1:0] jalr_imm,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_vec,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            fault;
    } entry_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc, req_pc, redir_pc, jalr_sum;
    logic            epoch, req_epoch;
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    entry_t          fifo [DEPTH];
    entry_t          push_entry;
    logic            redir, space, aligned, req_fire, fault_push, rsp_push, push, pop;

    assign redir    = br_take | jalr_take | trap_take;
    assign jalr_sum = jalr_r1 + jalr_imm;

    always_comb begin
        redir_pc = trap_vec;
        if (br_take)
            redir_pc = br_pc + br_imm;
        else if (jalr_take)
            redir_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end

    assign space          = count < FULL;
    assign aligned        = fetch_pc[1:0] == 2'b00;
    assign imem_req_valid = rst_n && state == S_REQ && aligned && space && !redir;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Misaligned target never reaches memory; it becomes a fault entry instead.
    assign fault_push = rst_n && state == S_REQ && !aligned && space && !redir;
    assign rsp_push   = rst_n && state == S_WAIT && imem_rsp_valid && req_epoch == epoch && !redir;
    assign push       = fault_push || rsp_push;

    always_comb begin
        push_entry.pc    = req_pc;
        push_entry.inst  = imem_rsp_data;
        push_entry.fault = 1'b0;
        if (fault_push) begin
            push_entry.pc    = fetch_pc;
            push_entry.inst  = 32'h0;
            push_entry.fault = 1'b1;
        end
    end

    assign out_valid = rst_n && count != '0;
    assign pop       = out_valid && out_ready;
    assign out_pc    = fifo[rd_ptr].pc;
    assign out_inst  = fifo[rd_ptr].inst;
    assign out_fault = fifo[rd_ptr].fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (redir) begin
            fetch_pc  <= redir_pc;
            epoch     <= ~epoch;
            // Pin to the pre-toggle epoch so back-to-back redirects cannot re-match it.
            req_epoch <= epoch;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= (state == S_WAIT && !imem_rsp_valid) ? S_WAIT : S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc    <= fetch_pc;
                        req_epoch <= epoch;
                        fetch_pc  <= fetch_pc + XLEN'(4);
                        state     <= S_WAIT;
                    end else if (fault_push) begin
                        state <= S_HALT;
                    end
                end
                S_WAIT: if (imem_rsp_valid) state <= S_REQ;
                default: ;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_entry;
    end

endmodule

// File: tb/tb_ysyx_22041207_ifu_buf.sv
// Directed bench for ysyx_22041207_ifu_buf: a small imem responder with configurable
// latency, request/pop logs, and hand-computed expected addresses and entries.
module tb_ysyx_22041207_ifu_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_take, jalr_take, trap_take;
    logic [63:0] br_pc, br_imm, jalr_r1, jalr_imm, trap_vec;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    ysyx_22041207_ifu_buf #(.XLEN(64), .RESET_PC(64'h8000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_take(br_take), .br_pc(br_pc), .br_imm(br_imm),
        .jalr_take(jalr_take), .jalr_r1(jalr_r1), .jalr_imm(jalr_imm),
        .trap_take(trap_take), .trap_vec(trap_vec),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } pop_t;

    logic [63:0] req_log[$];
    pop_t        pop_log[$];
    pop_t        pe;
    int          lat = 1;
    int          n_cmp = 0, n_err = 0;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_addr = 64'h0;
    logic [31:0] t1_inst [3] = '{32'h7fff_ffff, 32'h7fff_fffb, 32'h7fff_fff7};

    // imem responder: data = ~addr[31:0], returned lat cycles after acceptance
    always begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            m_pend = 1'b1;
            m_cnt  = lat;
            m_addr = imem_req_addr;
        end
        if (out_valid && out_ready) begin
            pe.pc    = out_pc;
            pe.inst  = out_inst;
            pe.fault = out_fault;
            pop_log.push_back(pe);
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~m_addr[31:0];
                m_pend         = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic wait_logs(input int nreq, input int npop, input string tag);
        int k = 0;
        while ((req_log.size() < nreq || pop_log.size() < npop) && k < 200) begin
            step();
            k++;
        end
        chk(tag, 64'(req_log.size() >= nreq && pop_log.size() >= npop), 64'd1);
    endtask

    task automatic clear_takes();
        br_take = 1'b0; jalr_take = 1'b0; trap_take = 1'b0;
    endtask

    initial begin
        clear_takes();
        br_pc = 0; br_imm = 0; jalr_r1 = 0; jalr_imm = 0; trap_vec = 0;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;

        // reset state
        step();
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);

        // streaming fetch from RESET_PC
        do_reset();
        @(negedge clk);
        chk("t1_req_valid", imem_req_valid, 1);
        chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
        step(); @(negedge clk);
        chk("t1_lat_out_valid", out_valid, 0);
        step(); @(negedge clk);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_pc", out_pc, 64'h8000_0000);
        chk("t1_out_inst", out_inst, 64'h7fff_ffff);
        chk("t1_out_fault", out_fault, 0);
        wait_logs(3, 3, "t1_wait");
        if (req_log.size() >= 3 && pop_log.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                chk("t1_req_addr_seq", req_log[i], 64'h8000_0000 + 64'(4 * i));
                chk("t1_pop_pc", pop_log[i].pc, 64'h8000_0000 + 64'(4 * i));
                chk("t1_pop_inst", pop_log[i].inst, t1_inst[i]);
                chk("t1_pop_fault", pop_log[i].fault, 0);
            end

        // back-pressure fills the FIFO, then drains in order
        out_ready = 1'b0;
        do_reset();
        repeat (20) step();
        @(negedge clk);
        chk("t2_req_count", req_log.size(), 4);
        chk("t2_req_valid_full", imem_req_valid, 0);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_head_pc", out_pc, 64'h8000_0000);
        chk("t2_head_inst", out_inst, 64'h7fff_ffff);
        chk("t2_no_pops", pop_log.size(), 0);
        if (req_log.size() >= 4)
            chk("t2_last_req", req_log[3], 64'h8000_000c);
        step();
        out_ready = 1'b1;
        wait_logs(5, 4, "t2_wait");
        if (req_log.size() >= 5 && pop_log.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk("t2_pop_pc", pop_log[i].pc, 64'h8000_0000 + 64'(4 * i));
            chk("t2_resume_addr", req_log[4], 64'h8000_0010);
        end

        // branch while waiting squashes the in-flight response
        do_reset();
        lat = 2;
        @(negedge clk);
        chk("t3_req_valid", imem_req_valid, 1);
        step();
        br_take = 1'b1; br_pc = 64'h8000_0100; br_imm = 64'h20;
        @(negedge clk);
        chk("t3_redir_req_valid", imem_req_valid, 0);
        step();
        clear_takes();
        @(negedge clk);
        chk("t3_wait_req_valid", imem_req_valid, 0);
        chk("t3_drop_out_valid", out_valid, 0);
        step(); @(negedge clk);
        chk("t3_new_req_valid", imem_req_valid, 1);
        chk("t3_new_req_addr", imem_req_addr, 64'h8000_0120);
        chk("t3_empty_after_drop", out_valid, 0);
        wait_logs(2, 1, "t3_wait");
        if (pop_log.size() >= 1) begin
            chk("t3_pop_pc", pop_log[0].pc, 64'h8000_0120);
            chk("t3_pop_inst", pop_log[0].inst, 64'h7fff_fedf);
        end

        // redirect priority: br over jalr over trap, with wrapping add
        do_reset();
        lat = 1;
        br_take = 1'b1; br_pc = 64'h8000_0300; br_imm = 64'hffff_ffff_ffff_fffc;
        jalr_take = 1'b1; jalr_r1 = 64'h8000_0201; jalr_imm = 64'h0;
        trap_take = 1'b1; trap_vec = 64'h8000_1000;
        @(negedge clk);
        chk("t4_redir_req_valid", imem_req_valid, 0);
        step();
        clear_takes();
        @(negedge clk);
        chk("t4_br_req_valid", imem_req_valid, 1);
        chk("t4_br_addr", imem_req_addr, 64'h8000_02fc);
        do_reset();
        jalr_take = 1'b1;
        @(negedge clk);
        chk("t4_jalr_redir_valid", imem_req_valid, 0);
        step();
        clear_takes();
        @(negedge clk);
        chk("t4_jalr_addr", imem_req_addr, 64'h8000_0200);
        chk("t4_jalr_req_valid", imem_req_valid, 1);
        chk("t4_jalr_out_valid", out_valid, 0);

        // misaligned trap target produces a fault entry and halts
        do_reset();
        trap_take = 1'b1; trap_vec = 64'h8000_1002;
        @(negedge clk);
        chk("t5_redir_req_valid", imem_req_valid, 0);
        step();
        clear_takes();
        @(negedge clk);
        chk("t5_no_req", imem_req_valid, 0);
        chk("t5_not_yet_valid", out_valid, 0);
        step(); @(negedge clk);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_out_fault", out_fault, 1);
        chk("t5_out_pc", out_pc, 64'h8000_1002);
        chk("t5_out_inst", out_inst, 0);
        chk("t5_halt_req_valid", imem_req_valid, 0);
        repeat (5) step();
        @(negedge clk);
        chk("t5_halt_out_valid", out_valid, 0);
        chk("t5_halt_pops", pop_log.size(), 1);
        chk("t5_halt_reqs", req_log.size(), 0);
        step();
        br_take = 1'b1; br_pc = 64'h8000_0400; br_imm = 64'h0;
        @(negedge clk);
        chk("t5_leave_redir_valid", imem_req_valid, 0);
        step();
        clear_takes();
        @(negedge clk);
        chk("t5_leave_req_valid", imem_req_valid, 1);
        chk("t5_leave_addr", imem_req_addr, 64'h8000_0400);

        // reset while waiting; stale response lands in REQ and is ignored
        do_reset();
        lat = 3;
        @(negedge clk);
        chk("t6_req_valid", imem_req_valid, 1);
        step();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("t6_rst_req_valid", imem_req_valid, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_valid", imem_req_valid, 1);
        chk("t6_restart_addr", imem_req_addr, 64'h8000_0000);
        step(); @(negedge clk);
        chk("t6_stale_out_valid", out_valid, 0);
        chk("t6_hold_addr", imem_req_addr, 64'h8000_0000);
        step();
        imem_req_ready = 1'b1;
        lat = 1;
        @(negedge clk);
        chk("t6_after_stale_valid", out_valid, 0);
        step(); @(negedge clk);
        chk("t6_wait_out_valid", out_valid, 0);
        step(); @(negedge clk);
        chk("t6_new_out_valid", out_valid, 1);
        chk("t6_new_out_pc", out_pc, 64'h8000_0000);
        chk("t6_new_out_inst", out_inst, 64'h7fff_ffff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
